id_ex_stage: RTL and testbench

//  ID/EX pipeline register of the 5-stage MIPS core. Captures the decoder's control bundle
//  (RegDst..Jump, ALUOp) and the ID operands every cycle for the EX stage. Holds the

---
 rtl/id_ex_stage.sv | 143 ++++++++++++++
 tb/tb_id_ex_stage.sv | 189 ++++++++++++++++++
 2 files changed

// File: rtl/id_ex_stage.sv
// rtl/id_ex_stage.sv - ID/EX pipeline register with load-use hazard detection and flush bubbles
// Optional feature macro: ID_EX_PERF_EN (adds stall/flush event counters)
module id_ex_stage #(
  parameter int DATA_W = 32,
  parameter int REG_AW = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [11:0]       id_ctrl,
  input  logic [DATA_W-1:0] id_rd1,
  input  logic [DATA_W-1:0] id_rd2,
  input  logic [DATA_W-1:0] id_imm,
  input  logic [DATA_W-1:0] id_pc4,
  input  logic [REG_AW-1:0] id_rs,
  input  logic [REG_AW-1:0] id_rt,
  input  logic [REG_AW-1:0] id_rd,
  input  logic [REG_AW-1:0] id_shamt,
  input  logic [5:0]        id_funct,
  input  logic              flush,
  output logic              stall_o,
  output logic [11:0]       ex_ctrl,
  output logic [DATA_W-1:0] ex_rd1,
  output logic [DATA_W-1:0] ex_rd2,
  output logic [DATA_W-1:0] ex_imm,
  output logic [DATA_W-1:0] ex_pc4,
  output logic [REG_AW-1:0] ex_rs,
  output logic [REG_AW-1:0] ex_rt,
  output logic [REG_AW-1:0] ex_rd,
  output logic [REG_AW-1:0] ex_shamt,
  output logic [5:0]        ex_funct,
  output logic              ex_valid
`ifdef ID_EX_PERF_EN
  ,
  output logic [31:0]       perf_stall_cnt,
  output logic [31:0]       perf_flush_cnt
`endif
);

  // MemRead position inside the control bundle
  localparam int MEMREAD_BIT = 7;

  logic [11:0]       ex_ctrl_q,  ex_ctrl_d;
  logic [DATA_W-1:0] ex_rd1_q,   ex_rd1_d;
  logic [DATA_W-1:0] ex_rd2_q,   ex_rd2_d;
  logic [DATA_W-1:0] ex_imm_q,   ex_imm_d;
  logic [DATA_W-1:0] ex_pc4_q,   ex_pc4_d;
  logic [REG_AW-1:0] ex_rs_q,    ex_rs_d;
  logic [REG_AW-1:0] ex_rt_q,    ex_rt_d;
  logic [REG_AW-1:0] ex_rd_q,    ex_rd_d;
  logic [REG_AW-1:0] ex_shamt_q, ex_shamt_d;
  logic [5:0]        ex_funct_q, ex_funct_d;
  logic              ex_valid_q, ex_valid_d;
  logic              bubble;

  // Load-use hazard: a real load in EX whose nonzero destination is read by the ID instruction
  always_comb begin
    stall_o = !rst && ex_valid_q && ex_ctrl_q[MEMREAD_BIT] && (ex_rt_q != '0) &&
              ((ex_rt_q == id_rs) || (ex_rt_q == id_rt));
    bubble  = stall_o || flush;
  end

  // Next EX slot: a bubble only kills control and valid, operands always load
  always_comb begin
    ex_ctrl_d  = bubble ? 12'h000 : id_ctrl;
    ex_valid_d = !bubble;
    ex_rd1_d   = id_rd1;
    ex_rd2_d   = id_rd2;
    ex_imm_d   = id_imm;
    ex_pc4_d   = id_pc4;
    ex_rs_d    = id_rs;
    ex_rt_d    = id_rt;
    ex_rd_d    = id_rd;
    ex_shamt_d = id_shamt;
    ex_funct_d = id_funct;
  end

  // EX slot register; reset leaves a bubble
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ex_ctrl_q  <= '0;
      ex_rd1_q   <= '0;
      ex_rd2_q   <= '0;
      ex_imm_q   <= '0;
      ex_pc4_q   <= '0;
      ex_rs_q    <= '0;
      ex_rt_q    <= '0;
      ex_rd_q    <= '0;
      ex_shamt_q <= '0;
      ex_funct_q <= '0;
      ex_valid_q <= 1'b0;
    end else begin
      ex_ctrl_q  <= ex_ctrl_d;
      ex_rd1_q   <= ex_rd1_d;
      ex_rd2_q   <= ex_rd2_d;
      ex_imm_q   <= ex_imm_d;
      ex_pc4_q   <= ex_pc4_d;
      ex_rs_q    <= ex_rs_d;
      ex_rt_q    <= ex_rt_d;
      ex_rd_q    <= ex_rd_d;
      ex_shamt_q <= ex_shamt_d;
      ex_funct_q <= ex_funct_d;
      ex_valid_q <= ex_valid_d;
    end
  end

  assign ex_ctrl  = ex_ctrl_q;
  assign ex_rd1   = ex_rd1_q;
  assign ex_rd2   = ex_rd2_q;
  assign ex_imm   = ex_imm_q;
  assign ex_pc4   = ex_pc4_q;
  assign ex_rs    = ex_rs_q;
  assign ex_rt    = ex_rt_q;
  assign ex_rd    = ex_rd_q;
  assign ex_shamt = ex_shamt_q;
  assign ex_funct = ex_funct_q;
  assign ex_valid = ex_valid_q;

`ifdef ID_EX_PERF_EN
  logic [31:0] perf_stall_cnt_q, perf_stall_cnt_d;
  logic [31:0] perf_flush_cnt_q, perf_flush_cnt_d;

  // Event counters; free-running wrap at 2^32
  always_comb begin
    perf_stall_cnt_d = perf_stall_cnt_q + {31'd0, stall_o};
    perf_flush_cnt_d = perf_flush_cnt_q + {31'd0, flush};
  end

  // Counter registers, cleared by reset
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      perf_stall_cnt_q <= '0;
      perf_flush_cnt_q <= '0;
    end else begin
      perf_stall_cnt_q <= perf_stall_cnt_d;
      perf_flush_cnt_q <= perf_flush_cnt_d;
    end
  end

  assign perf_stall_cnt = perf_stall_cnt_q;
  assign perf_flush_cnt = perf_flush_cnt_q;
`endif

endmodule

// File: tb/tb_id_ex_stage.sv
// tb/tb_id_ex_stage.sv - randomized self-checking bench for id_ex_stage against a slot-level model
module tb_id_ex_stage;

  logic        clk;
  logic        rst;
  logic [11:0] id_ctrl;
  logic [31:0] id_rd1, id_rd2, id_imm, id_pc4;
  logic [4:0]  id_rs, id_rt, id_rd, id_shamt;
  logic [5:0]  id_funct;
  logic        flush;
  logic        stall_o;
  logic [11:0] ex_ctrl;
  logic [31:0] ex_rd1, ex_rd2, ex_imm, ex_pc4;
  logic [4:0]  ex_rs, ex_rt, ex_rd, ex_shamt;
  logic [5:0]  ex_funct;
  logic        ex_valid;
`ifdef ID_EX_PERF_EN
  logic [31:0] perf_stall_cnt, perf_flush_cnt;
`endif

  int total = 0;
  int bad   = 0;

  id_ex_stage dut (
    .clk(clk), .rst(rst), .id_ctrl(id_ctrl),
    .id_rd1(id_rd1), .id_rd2(id_rd2), .id_imm(id_imm), .id_pc4(id_pc4),
    .id_rs(id_rs), .id_rt(id_rt), .id_rd(id_rd), .id_shamt(id_shamt), .id_funct(id_funct),
    .flush(flush), .stall_o(stall_o), .ex_ctrl(ex_ctrl),
    .ex_rd1(ex_rd1), .ex_rd2(ex_rd2), .ex_imm(ex_imm), .ex_pc4(ex_pc4),
    .ex_rs(ex_rs), .ex_rt(ex_rt), .ex_rd(ex_rd), .ex_shamt(ex_shamt), .ex_funct(ex_funct),
    .ex_valid(ex_valid)
`ifdef ID_EX_PERF_EN
    , .perf_stall_cnt(perf_stall_cnt), .perf_flush_cnt(perf_flush_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Model of what instruction occupies the EX slot
  typedef struct {
    bit          valid;
    logic [11:0] ctrl;
    logic [31:0] rd1, rd2, imm, pc4;
    logic [4:0]  rs, rt, rd, shamt;
    logic [5:0]  funct;
  } slot_t;

  slot_t  m;
  longint m_stalls, m_flushes;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic bit model_stall();
    // a load in EX whose target register is read in ID must wait one cycle ($0 never counts)
    return m.valid && m.ctrl[7] && (m.rt != 0) && ((m.rt == id_rs) || (m.rt == id_rt));
  endfunction

  task automatic model_clear();
    m.valid = 0; m.ctrl = 0; m.rd1 = 0; m.rd2 = 0; m.imm = 0; m.pc4 = 0;
    m.rs = 0; m.rt = 0; m.rd = 0; m.shamt = 0; m.funct = 0;
    m_stalls = 0; m_flushes = 0;
  endtask

  task automatic check_ex(input string tag);
    check({tag, ".valid"}, 64'(ex_valid), 64'(m.valid));
    check({tag, ".ctrl"}, 64'(ex_ctrl), 64'(m.ctrl));
    if (m.valid) begin
      check({tag, ".ops"}, {ex_rd1, ex_rd2}, {m.rd1, m.rd2});
      check({tag, ".imm_pc4"}, {ex_imm, ex_pc4}, {m.imm, m.pc4});
      check({tag, ".fields"}, 64'({ex_rs, ex_rt, ex_rd, ex_shamt, ex_funct}),
            64'({m.rs, m.rt, m.rd, m.shamt, m.funct}));
    end
`ifdef ID_EX_PERF_EN
    check({tag, ".pstall"}, 64'(perf_stall_cnt), 64'(m_stalls[31:0]));
    check({tag, ".pflush"}, 64'(perf_flush_cnt), 64'(m_flushes[31:0]));
`endif
  endtask

  task automatic randomize_data();
    id_rd1 = $urandom; id_rd2 = $urandom; id_imm = $urandom; id_pc4 = $urandom;
    id_rd = 5'($urandom); id_shamt = 5'($urandom); id_funct = 6'($urandom);
  endtask

  // One pipeline cycle: present ID, check hazard, clock, check EX slot
  task automatic cycle(input string tag, input logic [11:0] ctrl, input logic [4:0] rs,
                       input logic [4:0] rt, input logic fl);
    bit es;
    id_ctrl = ctrl; id_rs = rs; id_rt = rt; flush = fl;
    randomize_data();
    #1;
    es = model_stall();
    check({tag, ".stall"}, 64'(stall_o), 64'(es));
    @(posedge clk);
    if (es) m_stalls++;
    if (fl) m_flushes++;
    if (es || fl) begin
      m.valid = 0; m.ctrl = 0;
    end else begin
      m.valid = 1; m.ctrl = id_ctrl;
      m.rd1 = id_rd1; m.rd2 = id_rd2; m.imm = id_imm; m.pc4 = id_pc4;
      m.rs = id_rs; m.rt = id_rt; m.rd = id_rd; m.shamt = id_shamt; m.funct = id_funct;
    end
    #1;
    check_ex(tag);
  endtask

  initial begin
    model_clear();
    rst = 1'b1;
    flush = 1'b0;
    id_ctrl = 12'($urandom); id_rs = 5'($urandom); id_rt = 5'($urandom);
    randomize_data();
    @(posedge clk);
    #1;
    check("reset.ctrl", 64'(ex_ctrl), 64'h0);
    check("reset.valid", 64'(ex_valid), 64'h0);
    check("reset.stall", 64'(stall_o), 64'h0);
    rst = 1'b0;

    cycle("rtype", 12'hC02, 5'd1, 5'd3, 1'b0);
    check("rtype.lit", 64'({ex_valid, ex_ctrl}), 64'h1C02);

    // load-use stall: exactly one bubble then the add proceeds
    cycle("lw8", 12'h6A4, 5'd2, 5'd8, 1'b0);
    cycle("use8", 12'hC02, 5'd8, 5'd5, 1'b0);
    check("use8.lit_bubble", 64'({ex_valid, ex_ctrl}), 64'h0);
    cycle("use8r", 12'hC02, 5'd8, 5'd5, 1'b0);
    check("use8r.lit", 64'({ex_valid, ex_ctrl}), 64'h1C02);

    // load to $0 never stalls
    cycle("lw0", 12'h6A4, 5'd2, 5'd0, 1'b0);
    cycle("use0", 12'hC02, 5'd0, 5'd0, 1'b0);
    check("use0.lit", 64'(ex_valid), 64'h1);

    // flush of a beq
    cycle("beqf", 12'h101, 5'd1, 5'd2, 1'b1);
    check("beqf.lit", 64'({ex_valid, ex_ctrl}), 64'h0);

    // stall and flush together give one bubble
    cycle("lw8b", 12'h6A4, 5'd2, 5'd8, 1'b0);
    cycle("stfl", 12'hC02, 5'd8, 5'd8, 1'b1);
    cycle("after", 12'h000, 5'd8, 5'd8, 1'b0);
    check("nop.valid", 64'(ex_valid), 64'h1);

    // sw reading the loaded register through rt, and a non-matching pair
    cycle("lw8c", 12'h6A4, 5'd2, 5'd8, 1'b0);
    cycle("sw8", 12'h230, 5'd3, 5'd8, 1'b0);
    cycle("lw8d", 12'h6A4, 5'd2, 5'd8, 1'b0);
    cycle("nomatch", 12'hC02, 5'd9, 5'd10, 1'b0);

    // randomized traffic with small register numbers so hazards are frequent
    for (int i = 0; i < 400; i++) begin
      logic [11:0] c;
      c = 12'($urandom);
      if ($urandom_range(0, 2) == 0) c[7] = 1'b1;
      cycle("rnd", c, 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
            ($urandom_range(0, 7) == 0));
      if (i == 200) begin
        // asynchronous reset in the middle of a cycle
        rst = 1'b1;
        #1;
        model_clear();
        check_ex("areset");
        check("areset.stall", 64'(stall_o), 64'h0);
        @(posedge clk);
        #1;
        rst = 1'b0;
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Hard bound on run time
  initial begin
    #200000;
    $display("FAIL timeout: got no finish expected finish");
    $fatal(1);
  end

endmodule
